// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that owns the single port of an external 32x4 RAM.
// Words are written into the RAM, read back one at a time and delivered through a one-word output register.
module ram_fifo_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              ram_enable,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              rd_pend_reg, rd_pend_next;
    logic              out_valid_reg, out_valid_next;
    logic [DATA_W-1:0] out_data_reg, out_data_next;

    logic rd_sel;
    logic wr_fire;

    // A read is only issued when the output register is guaranteed to be free when the data returns.
    assign rd_sel   = rst_n && !flush && (count_reg != '0) && !rd_pend_reg
                      && (!out_valid_reg || out_ready);
    assign in_ready = rst_n && !flush && !rd_sel && (count_reg != DEPTH_C);
    assign wr_fire  = in_valid && in_ready;

    assign ram_enable  = rd_sel || wr_fire;
    assign ram_wen     = wr_fire;
    assign ram_address = rd_sel ? rd_ptr_reg : wr_ptr_reg;
    assign ram_data_in = in_data;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        rd_pend_next   = rd_sel;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;

        if (flush) begin
            // The in-flight read, if any, is dropped by clearing rd_pend; out_data keeps its stale value.
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            rd_pend_next   = 1'b0;
            out_valid_next = 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
                count_next  = count_reg + 1'b1;
            end
            if (rd_sel) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
                count_next  = count_reg - 1'b1;
            end
            if (rd_pend_reg) begin
                out_data_next  = ram_data_out;
                out_valid_next = 1'b1;
            end else if (out_ready) begin
                out_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            rd_pend_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            rd_pend_reg   <= rd_pend_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign count     = count_reg;
    assign full      = (count_reg == DEPTH_C);
    assign empty     = (count_reg == '0) && !rd_pend_reg && !out_valid_reg;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM, queue reference model, directed and random traffic.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       ram_enable;
    logic       ram_wen;
    logic [4:0] ram_address;
    logic [3:0] ram_data_in;
    logic [3:0] ram_data_out = 4'h0;
    logic [5:0] count;
    logic       full;
    logic       empty;

    int tests = 0;
    int fails = 0;
    int pops  = 0;
    logic [3:0] q[$];
    logic [3:0] mem [32];

    ram_fifo_ctrl #(.ADDR_W(5), .DATA_W(4), .DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ram_enable(ram_enable), .ram_wen(ram_wen), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle registered read.
    initial for (int i = 0; i < 32; i++) mem[i] = 4'(i * 7);
    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_wen) mem[ram_address] <= ram_data_in;
            else         ram_data_out <= mem[ram_address];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: record acceptance before the edge, update the model after it.
    task automatic tick();
        logic acc;
        logic fl;
        logic [3:0] d;
        @(negedge clk);
        acc = in_valid && in_ready;
        fl  = flush;
        d   = in_data;
        @(posedge clk);
        if (fl) q.delete();
        else if (acc) q.push_back(d);
        #1;
    endtask

    // Monitor: every delivered word must be the oldest accepted one.
    always @(negedge clk) begin
        if (rst_n) begin
            check("empty_vs_model", int'(empty), int'(q.size() == 0));
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("spurious_out", 1, 0);
                else check("out_data", int'(out_data), int'(q.pop_front()));
                pops++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc, rd_idx, last_hs, p0, cyc;

        // Reset behaviour
        in_valid = 1'b1;
        #12;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_ram_enable", int'(ram_enable), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_count", int'(count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rel_in_ready", int'(in_ready), 1);

        // Single word latency
        in_valid = 1'b1; in_data = 4'hA; out_ready = 1'b0; #1;
        check("sw_t0_wen", int'(ram_enable && ram_wen), 1);
        check("sw_t0_addr", int'(ram_address), 0);
        tick();
        in_valid = 1'b0; #1;
        check("sw_t1_en", int'(ram_enable), 1);
        check("sw_t1_wen", int'(ram_wen), 0);
        check("sw_t1_addr", int'(ram_address), 0);
        tick();
        check("sw_t2_out_valid", int'(out_valid), 0);
        tick();
        check("sw_t3_out_valid", int'(out_valid), 1);
        check("sw_t3_out_data", int'(out_data), 'hA);
        check("sw_t3_count", int'(count), 0);
        check("sw_t3_empty", int'(empty), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Fill: 33 words fit (32 in RAM plus the output register)
        n_acc = 0;
        for (cyc = 0; cyc < 200 && n_acc < 33; cyc++) begin
            in_valid = 1'b1; in_data = 4'(n_acc); #1;
            if (ram_enable && ram_wen) check("fill_waddr", int'(ram_address), n_acc % 32);
            if (in_ready) n_acc++;
            tick();
        end
        check("fill_accepted", n_acc, 33);
        tick(); tick();
        check("fill_full", int'(full), 1);
        check("fill_count", int'(count), 32);
        check("fill_in_ready", int'(in_ready), 0);

        // Drain: words in order, one every two cycles, read address wraps
        in_valid = 1'b0; out_ready = 1'b1;
        p0 = pops; rd_idx = 1; last_hs = -1;
        for (cyc = 0; cyc < 200 && (pops - p0) < 33; cyc++) begin
            #1;
            if (ram_enable && !ram_wen) begin
                check("drain_raddr", int'(ram_address), rd_idx % 32);
                rd_idx++;
            end
            if (out_valid) begin
                if (last_hs >= 0) check("drain_spacing", cyc - last_hs, 2);
                last_hs = cyc;
            end
            tick();
        end
        check("drain_words", pops - p0, 33);
        check("drain_empty", int'(empty), 1);

        // Read wins over write
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'h5; #1;
        check("cf_t0_in_ready", int'(in_ready), 1);
        tick();
        in_data = 4'h6; #1;
        check("cf_t1_in_ready", int'(in_ready), 0);
        check("cf_t1_read", int'(ram_enable && !ram_wen), 1);
        tick();
        check("cf_t2_in_ready", int'(in_ready), 1);
        check("cf_t2_write", int'(ram_enable && ram_wen), 1);
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) tick();
        check("cf_empty", int'(empty), 1);

        // Flush with a read in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'hC;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1; #1;
        check("fl_no_ram", int'(ram_enable), 0);
        check("fl_in_ready", int'(in_ready), 0);
        tick();
        flush = 1'b0; #1;
        check("fl_out_valid", int'(out_valid), 0);
        check("fl_count", int'(count), 0);
        check("fl_empty", int'(empty), 1);
        out_ready = 1'b1;
        repeat (4) begin
            tick();
            check("fl_no_stale", int'(out_valid), 0);
        end

        // Random traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 4'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 99) == 0);
            tick();
        end
        flush = 1'b0;

        // Asynchronous reset in mid-operation
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", int'(count), 0);
        check("arst_empty", int'(empty), 1);
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_in_ready", int'(in_ready), 0);
        check("arst_ram_enable", int'(ram_enable), 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0; #1;
        check("arst_rel_in_ready", int'(in_ready), 1);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
